// File: rtl/ttl_161_fetch_sched.sv
// ttl_161_fetch_sched
// Round-robin burst scheduler for a shared, externally built chain of
// 74161-style loadable counters.  Two fetch requesters (e.g. tile and sprite
// line fetch) ask for bursts.  The winner's start address is parallel-loaded
// into the chain, and the chain is then counted up Len times.  The block
// steps only on the same Cen "tick" the counters use, so every registered
// output is captured by the chain on the following tick.
//
// Ports
//   Clk            system clock
//   Reset          asynchronous, active-high reset
//   Cen            clock enable; tick = Cen high now and low in the previous Clk cycle
//   Req0/Req1      level burst requests, held by the requester until granted
//   Addr0/Addr1    burst start addresses (WIDTH bits), sampled at the grant tick
//   Len0/Len1      increments per burst (LEN_W bits), sampled at the grant tick
//   Gnt0/Gnt1      requester owns the counter chain
//   Done0/Done1    burst finished, high for one tick period
//   Busy           a burst is in progress
//   Cnt_Load_bar   chain parallel-load strobe (active low)
//   Cnt_ENT        chain first-stage count enable
//   Cnt_ENP        chain count enable for all stages, always equal to Cnt_ENT
//   Cnt_D          chain parallel-load data
module ttl_161_fetch_sched #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cen,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Addr0,
  input  logic [LEN_W-1:0] Len0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Addr1,
  input  logic [LEN_W-1:0] Len1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic             Busy,
  output logic             Cnt_Load_bar,
  output logic             Cnt_ENT,
  output logic             Cnt_ENP,
  output logic [WIDTH-1:0] Cnt_D
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ADDR_ZERO = {WIDTH{1'b0}};

  state_t state_r, state_nxt_s;

  logic             last_cen_r;
  logic             tick_s;
  logic             win_vld_s;
  logic             win_sel_s;

  // owner_r: 0 = requester 0 holds the chain, 1 = requester 1
  logic             owner_r,    owner_nxt_s;
  logic             rr_last_r,  rr_last_nxt_s;
  logic [LEN_W-1:0] len_r,      len_nxt_s;
  logic [LEN_W-1:0] rem_r,      rem_nxt_s;
  logic [WIDTH-1:0] cnt_d_r,    cnt_d_nxt_s;
  logic             load_bar_r, load_bar_nxt_s;
  logic             ent_r,      ent_nxt_s;
  logic             gnt0_r,     gnt0_nxt_s;
  logic             gnt1_r,     gnt1_nxt_s;
  logic             done0_r,    done0_nxt_s;
  logic             done1_r,    done1_nxt_s;
  logic             busy_r,     busy_nxt_s;

  // Cen history for rising-edge tick detection; resets high so a Cen that is
  // already high when Reset drops does not count as a tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_cen_r <= 1'b1;
    end else begin
      last_cen_r <= Cen;
    end
  end

  assign tick_s = Cen & ~last_cen_r;

  // Round-robin arbitration: on a tie the requester that did not win last time wins.
  always_comb begin
    win_vld_s = 1'b0;
    win_sel_s = 1'b0;
    if (Req0 && Req1) begin
      win_vld_s = 1'b1;
      win_sel_s = ~rr_last_r;
    end else if (Req0) begin
      win_vld_s = 1'b1;
      win_sel_s = 1'b0;
    end else if (Req1) begin
      win_vld_s = 1'b1;
      win_sel_s = 1'b1;
    end else begin
      win_vld_s = 1'b0;
      win_sel_s = 1'b0;
    end
  end

  // FSM state register, advanced only on ticks.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else if (tick_s) begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (len_r == LEN_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rem_r == LEN_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the datapath and the registered chain/handshake outputs.
  // The chain sees these one tick later: Load_bar low in IDLE->LOAD makes the
  // chain load on the LOAD tick, enables set in LOAD->RUN make it count on RUN ticks.
  always_comb begin
    owner_nxt_s    = owner_r;
    rr_last_nxt_s  = rr_last_r;
    len_nxt_s      = len_r;
    rem_nxt_s      = rem_r;
    cnt_d_nxt_s    = cnt_d_r;
    load_bar_nxt_s = load_bar_r;
    ent_nxt_s      = ent_r;
    gnt0_nxt_s     = gnt0_r;
    gnt1_nxt_s     = gnt1_r;
    done0_nxt_s    = done0_r;
    done1_nxt_s    = done1_r;
    busy_nxt_s     = busy_r;
    case (state_r)
      ST_IDLE: begin
        done0_nxt_s = 1'b0;
        done1_nxt_s = 1'b0;
        if (win_vld_s) begin
          owner_nxt_s    = win_sel_s;
          rr_last_nxt_s  = win_sel_s;
          cnt_d_nxt_s    = win_sel_s ? Addr1 : Addr0;
          len_nxt_s      = win_sel_s ? Len1 : Len0;
          gnt0_nxt_s     = ~win_sel_s;
          gnt1_nxt_s     = win_sel_s;
          busy_nxt_s     = 1'b1;
          load_bar_nxt_s = 1'b0;
          ent_nxt_s      = 1'b0;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_LOAD: begin
        load_bar_nxt_s = 1'b1;
        if (len_r == LEN_ZERO) begin
          // Zero-length burst: the loaded address is the whole burst.
          ent_nxt_s   = 1'b0;
          done0_nxt_s = ~owner_r;
          done1_nxt_s = owner_r;
          gnt0_nxt_s  = 1'b0;
          gnt1_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b0;
        end else begin
          ent_nxt_s = 1'b1;
          rem_nxt_s = len_r - LEN_ONE;
        end
      end
      ST_RUN: begin
        if (rem_r == LEN_ZERO) begin
          // This tick makes the final increment; stop the chain there.
          ent_nxt_s   = 1'b0;
          done0_nxt_s = ~owner_r;
          done1_nxt_s = owner_r;
          gnt0_nxt_s  = 1'b0;
          gnt1_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b0;
        end else begin
          rem_nxt_s = rem_r - LEN_ONE;
        end
      end
      default: begin
        load_bar_nxt_s = 1'b1;
        ent_nxt_s      = 1'b0;
        gnt0_nxt_s     = 1'b0;
        gnt1_nxt_s     = 1'b0;
        done0_nxt_s    = 1'b0;
        done1_nxt_s    = 1'b0;
        busy_nxt_s     = 1'b0;
      end
    endcase
  end

  // Datapath and output registers, updated only on ticks.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      owner_r    <= 1'b0;
      rr_last_r  <= 1'b1;
      len_r      <= LEN_ZERO;
      rem_r      <= LEN_ZERO;
      cnt_d_r    <= ADDR_ZERO;
      load_bar_r <= 1'b1;
      ent_r      <= 1'b0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else if (tick_s) begin
      owner_r    <= owner_nxt_s;
      rr_last_r  <= rr_last_nxt_s;
      len_r      <= len_nxt_s;
      rem_r      <= rem_nxt_s;
      cnt_d_r    <= cnt_d_nxt_s;
      load_bar_r <= load_bar_nxt_s;
      ent_r      <= ent_nxt_s;
      gnt0_r     <= gnt0_nxt_s;
      gnt1_r     <= gnt1_nxt_s;
      done0_r    <= done0_nxt_s;
      done1_r    <= done1_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign Gnt0         = gnt0_r;
  assign Gnt1         = gnt1_r;
  assign Done0        = done0_r;
  assign Done1        = done1_r;
  assign Busy         = busy_r;
  assign Cnt_Load_bar = load_bar_r;
  assign Cnt_ENT      = ent_r;
  assign Cnt_ENP      = ent_r;
  assign Cnt_D        = cnt_d_r;

endmodule
